// File: rtl/crc_stream_engine.sv
// Bit-serial MSB-first CRC engine over a stream of DATA_W-bit words, one bit per clock.
// Optional expected-CRC compare port enabled by defining CRC_STREAM_CHECK_EN.
module crc_stream_engine #(
    parameter int                 CRC_W  = 5,
    parameter logic [CRC_W-1:0]   POLY   = 5'b00011,
    parameter int                 DATA_W = 32,
    parameter logic [CRC_W-1:0]   INIT   = '0,
    parameter logic [CRC_W-1:0]   XOROUT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid,
    input  logic              crc_ready,
`ifdef CRC_STREAM_CHECK_EN
    input  logic [CRC_W-1:0]  exp_crc,
    output logic              crc_ok,
`endif
    output logic              busy
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                fb;

    assign in_ready  = (state_q == IDLE) || (state_q == WAIT);
    assign busy      = (state_q != IDLE);
    assign crc_valid = (state_q == DONE);
    // Outside DONE the output is pinned so partial CRCs are never visible.
    assign crc_out   = crc_valid ? (crc_q ^ XOROUT) : (INIT ^ XOROUT);
    assign fb        = crc_q[CRC_W-1] ^ sreg_q[DATA_W-1];

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE, WAIT: begin
                if (in_valid) begin
                    if (state_q == IDLE) crc_d = INIT;
                    sreg_d  = in_data;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    last_d  = in_last;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                crc_d  = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
                sreg_d = sreg_q << 1;
                if (cnt_q == '0) state_d = last_q ? DONE : WAIT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                if (crc_ready) begin
                    state_d = IDLE;
                    crc_d   = INIT;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            crc_d   = INIT;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            sreg_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

`ifdef CRC_STREAM_CHECK_EN
    logic [CRC_W-1:0] exp_q, exp_d;

    always_comb begin
        exp_d = exp_q;
        if (in_ready && in_valid && in_last && !abort) exp_d = exp_crc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= '0;
        else        exp_q <= exp_d;
    end

    assign crc_ok = crc_valid && (crc_out == exp_q);
`endif
endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed-vector bench for crc_stream_engine at default parameters (G(x)=x^5+x+1).
module tb_crc_stream_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [4:0]  crc_out;
    logic        crc_valid;
    logic        crc_ready = 1'b0;
    logic        busy;
`ifdef CRC_STREAM_CHECK_EN
    logic [4:0]  exp_crc = '0;
    logic        crc_ok;
`endif

    int nvec = 0;
    int nerr = 0;
    int lat;

    always #5 clk = ~clk;

    crc_stream_engine dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .crc_out(crc_out), .crc_valid(crc_valid), .crc_ready(crc_ready),
`ifdef CRC_STREAM_CHECK_EN
        .exp_crc(exp_crc), .crc_ok(crc_ok),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a word from a negedge; returns #1 after the accepting edge with in_valid dropped.
    task automatic send(input logic [31:0] w, input logic last);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 0, 1);
        in_data  = w;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the handshake until crc_valid rises.
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!crc_valid && cycles < 200);
        if (!crc_valid) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic release_result();
        @(negedge clk);
        crc_ready = 1'b1;
        @(posedge clk);
        #1;
        crc_ready = 1'b0;
        chk("rel_valid", crc_valid, 0);
        chk("rel_busy", busy, 0);
        chk("rel_ready", in_ready, 1);
        chk("rel_out", crc_out, 5'h00);
    endtask

    initial begin
        #12;
        chk("rst_valid", crc_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", crc_out, 5'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1);

        // single word 1 -> x^5 mod G = x+1
        send(32'h0000_0001, 1'b1);
        chk("shift_busy", busy, 1);
        chk("shift_ready", in_ready, 0);
        wait_done(lat);
        chk("lat", lat, 32);
        chk("w1_crc", crc_out, 5'h03);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!crc_valid || crc_out !== 5'h03 || in_ready) chk("hold", {crc_valid, in_ready, crc_out}, {1'b1, 1'b0, 5'h03});
        end
        chk("hold_crc", crc_out, 5'h03);
        chk("hold_ready", in_ready, 0);
        release_result();

        // two words with a gap in WAIT
        send(32'h0000_0000, 1'b0);
        wait_ready();
        chk("wait_busy", busy, 1);
        chk("wait_valid", crc_valid, 0);
        chk("wait_out", crc_out, 5'h00);
        repeat (5) @(posedge clk);
        chk("wait_hold", in_ready, 1);
        send(32'h0000_0001, 1'b1);
        wait_done(lat);
        chk("two_crc", crc_out, 5'h03);
        release_result();

        send(32'h0000_0002, 1'b1);
        wait_done(lat);
        chk("w2_crc", crc_out, 5'h06);
        release_result();

        // x^6 + x^5 -> (x^2+x) ^ (x+1) = x^2+1
        send(32'h0000_0003, 1'b1);
        wait_done(lat);
        chk("w3_crc", crc_out, 5'h05);
        release_result();

        // in_valid held busy-side with junk must be ignored
        send(32'h0000_0001, 1'b1);
        in_data  = 32'hFFFF_FFFF;
        in_last  = 1'b1;
        in_valid = 1'b1;
        wait_done(lat);
        in_valid = 1'b0;
        chk("ign_crc", crc_out, 5'h03);
        chk("ign_lat", lat, 32);
        release_result();

        // abort mid-shift, then a clean zero message
        send(32'hFFFF_FFFF, 1'b1);
        repeat (11) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", crc_valid, 0);
        chk("abort_out", crc_out, 5'h00);
        send(32'h0000_0000, 1'b1);
        wait_done(lat);
        chk("zero_crc", crc_out, 5'h00);
        release_result();

        // abort wins over a simultaneous handshake in IDLE
        @(negedge clk);
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h0000_0001;
        @(posedge clk);
        #1;
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_hs_busy", busy, 0);

        // async reset while in DONE
        send(32'h0000_0001, 1'b1);
        wait_done(lat);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstdone_valid", crc_valid, 0);
        chk("rstdone_out", crc_out, 5'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstdone_ready", in_ready, 1);
        chk("rstdone_busy", busy, 0);

`ifdef CRC_STREAM_CHECK_EN
        exp_crc = 5'h03;
        send(32'h0000_0001, 1'b1);
        exp_crc = 5'h1F;
        wait_done(lat);
        chk("ok_match", crc_ok, 1);
        release_result();
        chk("ok_idle", crc_ok, 0);
        exp_crc = 5'h04;
        send(32'h0000_0001, 1'b1);
        wait_done(lat);
        chk("ok_miss", crc_ok, 0);
        release_result();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 Parameters SHALL be, one per line:
- CRC_W, 5: CRC register width, legal range 2..32.
- POLY, 5'b00011: generator polynomial, implicit x^CRC_W term omitted (default G(x)=x^5+x+1).
- DATA_W, 32: input word width, legal range 1..64.
- INIT, 0: CRC register value at message start.
- XOROUT, 0: value XORed into crc_out.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- abort  in  1  synchronous message cancel.
- in_data  in  DATA_W  message word, MSB transmitted first.
- in_valid  in  1  word offered.
- in_last  in  1  word is final word of message.
- in_ready  out  1  engine accepts a word this cycle.
- crc_out  out  CRC_W  result, stable while crc_valid=1.
- crc_valid  out  1  result available.
- crc_ready  in  1  consumer takes result.
- busy  out  1  message in progress (state != IDLE).

Function
REQ-003 Algorithm SHALL be non-reflected MSB-first LFSR, one bit per clock: fb=crc[CRC_W-1]^bit; crc<=(crc<<1)^(fb ? POLY : 0).
REQ-004 With INIT=0, XOROUT=0, the result SHALL equal M(x)*x^CRC_W mod G(x), M = concatenation of all accepted words.
REQ-005 FSM states SHALL be IDLE, SHIFT, WAIT, DONE.
REQ-006 IDLE: in_ready=1; on in_valid, crc<=INIT and the word is latched into the shift register, bit counter<=DATA_W-1, last flag<=in_last, ->SHIFT.
REQ-007 SHIFT: in_ready=0; one bit processed per cycle; after DATA_W cycles -> DONE if last flag set, else ->WAIT.
REQ-008 WAIT: in_ready=1; crc retained (not reinitialised); on in_valid, latch word and last flag, ->SHIFT.
REQ-009 DONE: crc_valid=1, crc_out=crc^XOROUT; on crc_ready ->IDLE; crc_out and crc_valid SHALL hold until crc_ready.
REQ-010 Latency: word handshake on edge k -> DATA_W SHIFT cycles -> crc_valid high from edge k+DATA_W for a last word.
REQ-011 Throughput: at most one word per DATA_W+1 cycles; in_valid while in_ready=0 SHALL be ignored without side effect.
REQ-012 in_valid is not required to stay high across gaps; WAIT SHALL hold indefinitely.
REQ-013 abort=1 in any state SHALL force IDLE next edge, crc<=INIT, crc_valid<=0, overriding any simultaneous handshake.
REQ-014 crc_out SHALL read INIT^XOROUT whenever crc_valid=0 (no internal state leak).
REQ-015 Bit counter SHALL be $clog2(DATA_W) bits minimum 1 and SHALL not wrap past 0.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, crc=INIT, counter=0, in_ready=1 after release, crc_valid=0, busy=0.
REQ-017 Reset mid-SHIFT or in DONE SHALL discard the message; no partial result SHALL ever appear.

Configuration
REQ-018 Macro CRC_STREAM_CHECK_EN SHALL control a check feature.
REQ-019 Defined: adds input exp_crc [CRC_W-1:0], latched on the last-word handshake, and output crc_ok, = (crc_out==exp_crc) while crc_valid=1, else 0.
REQ-020 Undefined: exp_crc and crc_ok SHALL not exist; all other behaviour identical.

Verification (defaults unless stated)
REQ-021 Word 32'h00000001 with in_last -> crc_valid at +32 cycles, crc_out=5'h03.
REQ-022 Words 32'h00000000 then 32'h00000001 (last), 5-cycle gap in WAIT -> crc_out=5'h03; 32'h00000002 alone -> 5'h06.
REQ-023 crc_ready held low 10 cycles in DONE -> crc_out/crc_valid stable, in_ready=0; crc_ready=1 -> IDLE next edge.
REQ-024 abort at SHIFT cycle 12, then 32'h00000000 last -> crc_out=5'h00; rst_n pulse in DONE -> crc_valid=0 immediately.
REQ-025 CRC_STREAM_CHECK_EN: 32'h00000001 with exp_crc=5'h03 -> crc_ok=1; exp_crc=5'h04 -> crc_ok=0.
